uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parallel-to-serial UART frame transmitter. It is the transmit-side counterpart of the team's serial-to-parallel receive path. It accepts a data word on a one-cycle start strobe and emits a frame on serial_out: start bit (0), data LSB first, an optional parity bit, and a stop bit (1). Each bit is held for BIT_PERIOD clocks. The block sits between the host-side register interface and the TX pin, and the line idles high to match the receiver's idle/reset level.

Parameters:
NUM_BITS, 8, data bits per frame (legal 5..9)
BIT_PERIOD, 10, clocks per serial bit (legal 2..1023)
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset, asynchronous, active-low
tx_start  input  1  request to send tx_data; sampled only in IDLE
tx_data  input  NUM_BITS  word to transmit; latched on accepted tx_start
serial_out  output  1  serial line, registered, idle high
tx_busy  output  1  high from the accepting edge until the frame completes
tx_done  output  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset (n_rst=0, takes effect immediately, including mid-frame): serial_out=1, tx_busy=0, tx_done=0, FSM=IDLE, bit-timer=0, bit-index=0, shift register all 1s.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: serial_out=1.
  - On tx_start=1 at edge E0: latch tx_data into the shift register, compute the parity bit from the latched data, go to START, set serial_out=0 and tx_busy=1.
- Bit timer: counts 0..BIT_PERIOD-1 and clears on each state or bit change. Every bit is driven for exactly BIT_PERIOD cycles.
- START: after BIT_PERIOD cycles, go to DATA with serial_out=data[0].
- DATA: shift right once per bit period. bit-index counts 0..NUM_BITS-1. After the last data bit:
  - go to PARITY if PARITY_EN=1;
  - otherwise go to STOP.
- PARITY: serial_out = XOR(data) ^ PARITY_ODD, so that (data ones + parity bit) is even for even parity and odd for odd parity. Hold for BIT_PERIOD cycles, then go to STOP.
- STOP: serial_out=1 for BIT_PERIOD cycles. At edge E_F, go to IDLE with tx_busy=0 and tx_done=1 for exactly one cycle.
  - E_F = E0 + (NUM_BITS+2+PARITY_EN)*BIT_PERIOD.
- Transitions: serial_out changes only on bit-period boundaries. The bit boundary for the bit starting at index k is at E0 + k*BIT_PERIOD.
- tx_start while tx_busy=1: ignored, no queueing.
- tx_data changes mid-frame: no effect, because the data is latched at acceptance.
- Back-to-back frames: tx_start is accepted in the tx_done cycle (the FSM is IDLE then). The line is therefore high for at least BIT_PERIOD+1 cycles between frames.
- tx_start held high continuously: frames repeat with that minimum gap.
- Reset asserted, then released: the next frame starts only on a fresh tx_start.
- Width rules:
  - bit-timer width = clog2(BIT_PERIOD);
  - bit-index width = clog2(NUM_BITS+1);
  - neither counter wraps past its terminal value.

Test Plan:
- Reset (defaults) -> serial_out=1, tx_busy=0, tx_done=0. No transitions for 50 cycles with tx_start=0.
- tx_data=0xA5, 1-cycle tx_start, PARITY_EN=0 -> serial_out = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. tx_busy high for 100 cycles. tx_done pulses once at E0+100.
- PARITY_EN=1, PARITY_ODD=0, tx_data=0x07:
  - frame is 0,1,1,1,0,0,0,0,0, parity=1, stop=1;
  - tx_done at E0+110;
  - repeat with PARITY_ODD=1 -> parity bit=0.
- Start 0x3C, then at E0+25 pulse tx_start with tx_data=0xFF and change tx_data -> the 0x3C frame is unchanged, no second frame, exactly one tx_done.
- Hold tx_start=1 with tx_data=0x55 across two frames -> the second start bit falls at E0+101. Line high exactly 11 cycles between frames. Two tx_done pulses, 101 cycles apart.
- Assert n_rst=0 at E0+43 (mid data bit 3) -> serial_out=1 and tx_busy=0 immediately, no tx_done. After release, tx_start with 0x81 produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_tx_frame
// Brief   : Parallel-to-serial UART frame transmitter (start, data LSB first,
//           optional parity, stop). Every output is registered.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int NUM_BITS   = 8,
    parameter int BIT_PERIOD = 10,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                tx_start,
    input  logic [NUM_BITS-1:0] tx_data,
    output logic                serial_out,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam int c_TIMER_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int c_INDEX_W = $clog2(NUM_BITS + 1);

    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = c_TIMER_W'(BIT_PERIOD - 1);
    localparam logic [c_INDEX_W-1:0] c_INDEX_MAX = c_INDEX_W'(NUM_BITS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]           r_state,  w_state;
    logic [c_TIMER_W-1:0] r_timer,  w_timer;
    logic [c_INDEX_W-1:0] r_index,  w_index;
    logic [NUM_BITS-1:0]  r_shift,  w_shift;
    logic                 r_parity, w_parity;
    logic                 r_serial, w_serial;
    logic                 r_busy,   w_busy;
    logic                 r_done,   w_done;
    logic                 w_bit_end;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= c_IDLE;
            r_timer  <= '0;
            r_index  <= '0;
            r_shift  <= '1;
            r_parity <= 1'b0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_timer  <= w_timer;
            r_index  <= w_index;
            r_shift  <= w_shift;
            r_parity <= w_parity;
            r_serial <= w_serial;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_timer   = r_timer;
        w_index   = r_index;
        w_shift   = r_shift;
        w_parity  = r_parity;
        w_serial  = r_serial;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_bit_end = (r_timer == c_TIMER_MAX);

        // Timer restarts at every bit boundary so each bit lasts BIT_PERIOD clocks
        if (r_state != c_IDLE) begin
            w_timer = w_bit_end ? '0 : r_timer + 1'b1;
        end

        case (r_state)
            c_IDLE: begin
                w_serial = 1'b1;
                if (tx_start) begin
                    w_state  = c_START;
                    w_shift  = tx_data;
                    w_parity = (^tx_data) ^ (PARITY_ODD != 0);
                    w_serial = 1'b0;
                    w_busy   = 1'b1;
                    w_timer  = '0;
                    w_index  = '0;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    w_state  = c_DATA;
                    w_serial = r_shift[0];
                    w_shift  = {1'b1, r_shift[NUM_BITS-1:1]};
                    w_index  = '0;
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    if (r_index == c_INDEX_MAX) begin
                        if (PARITY_EN != 0) begin
                            w_state  = c_PARITY;
                            w_serial = r_parity;
                        end else begin
                            w_state  = c_STOP;
                            w_serial = 1'b1;
                        end
                    end else begin
                        w_index  = r_index + 1'b1;
                        w_serial = r_shift[0];
                        w_shift  = {1'b1, r_shift[NUM_BITS-1:1]};
                    end
                end
            end
            c_PARITY: begin
                if (w_bit_end) begin
                    w_state  = c_STOP;
                    w_serial = 1'b1;
                end
            end
            c_STOP: begin
                if (w_bit_end) begin
                    w_state  = c_IDLE;
                    w_serial = 1'b1;
                    w_busy   = 1'b0;
                    w_done   = 1'b1;
                    w_index  = '0;
                end
            end
            default: begin
                w_state  = c_IDLE;
                w_serial = 1'b1;
                w_busy   = 1'b0;
                w_timer  = '0;
                w_index  = '0;
            end
        endcase
    end

    assign serial_out = r_serial;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// Directed self-checking bench for uart_tx_frame: one instance without parity,
// one with even parity and one with odd parity (all 8 data bits, 10 clocks/bit).
module tb_uart_tx_frame;

    logic       clk;
    logic       n_rst;
    logic       s0_start, s1_start, s2_start;
    logic [7:0] s0_data,  s1_data,  s2_data;
    logic       s0_out,   s1_out,   s2_out;
    logic       s0_busy,  s1_busy,  s2_busy;
    logic       s0_done,  s1_done,  s2_done;

    int checks = 0;
    int errors = 0;

    uart_tx_frame #(.NUM_BITS(8), .BIT_PERIOD(10), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .tx_start(s0_start), .tx_data(s0_data),
        .serial_out(s0_out), .tx_busy(s0_busy), .tx_done(s0_done));

    uart_tx_frame #(.NUM_BITS(8), .BIT_PERIOD(10), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .n_rst(n_rst), .tx_start(s1_start), .tx_data(s1_data),
        .serial_out(s1_out), .tx_busy(s1_busy), .tx_done(s1_done));

    uart_tx_frame #(.NUM_BITS(8), .BIT_PERIOD(10), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .n_rst(n_rst), .tx_start(s2_start), .tx_data(s2_data),
        .serial_out(s2_out), .tx_busy(s2_busy), .tx_done(s2_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for frame bit k (0 = start bit)
    function automatic logic exp_bit(input logic [8:0] d, input int n, input int pe,
                                     input int po, input int k);
        logic p;
        p = (po != 0);
        for (int i = 0; i < n; i++) p = p ^ d[i];
        if (k == 0) return 1'b0;
        if (k <= n) return d[k-1];
        if (pe != 0 && k == n + 1) return p;
        return 1'b1;
    endfunction

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s0_out, s0_busy, s0_done, s1_out, s1_busy, s1_done, s2_out, s2_busy, s2_done} !== 9'b100100100) begin
            errors++;
            $display("FAIL reset_hold got %b %b %b exp 100 100 100", {s0_out, s0_busy, s0_done},
                     {s1_out, s1_busy, s1_done}, {s2_out, s2_busy, s2_done});
        end
        n_rst = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            checks++;
            if ({s0_out, s0_busy, s0_done, s1_out, s1_busy, s1_done, s2_out, s2_busy, s2_done} !== 9'b100100100) begin
                errors++;
                $display("FAIL reset_idle t=%0d got %b %b %b exp 100 100 100", t, {s0_out, s0_busy, s0_done},
                         {s1_out, s1_busy, s1_done}, {s2_out, s2_busy, s2_done});
            end
        end
    endtask

    task automatic test_frame_a5;
        logic [2:0] exp;
        @(negedge clk); s0_start = 1'b1; s0_data = 8'hA5;
        @(negedge clk); s0_start = 1'b0; s0_data = 8'h00;
        for (int t = 0; t <= 101; t++) begin
            if (t < 100)       exp = {exp_bit(9'h0A5, 8, 0, 0, t / 10), 2'b10};
            else if (t == 100) exp = 3'b101;
            else               exp = 3'b100;
            checks++;
            if ({s0_out, s0_busy, s0_done} !== exp) begin
                errors++;
                $display("FAIL frame_a5 t=%0d got %b exp %b", t, {s0_out, s0_busy, s0_done}, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_parity;
        logic [2:0] e1, e2;
        @(negedge clk); s1_start = 1'b1; s1_data = 8'h07; s2_start = 1'b1; s2_data = 8'h07;
        @(negedge clk); s1_start = 1'b0; s2_start = 1'b0;
        for (int t = 0; t <= 111; t++) begin
            if (t < 110) begin
                e1 = {exp_bit(9'h007, 8, 1, 0, t / 10), 2'b10};
                e2 = {exp_bit(9'h007, 8, 1, 1, t / 10), 2'b10};
            end else if (t == 110) begin
                e1 = 3'b101; e2 = 3'b101;
            end else begin
                e1 = 3'b100; e2 = 3'b100;
            end
            checks++;
            if ({s1_out, s1_busy, s1_done} !== e1) begin
                errors++;
                $display("FAIL parity_even t=%0d got %b exp %b", t, {s1_out, s1_busy, s1_done}, e1);
            end
            checks++;
            if ({s2_out, s2_busy, s2_done} !== e2) begin
                errors++;
                $display("FAIL parity_odd t=%0d got %b exp %b", t, {s2_out, s2_busy, s2_done}, e2);
            end
            if (t == 95) begin
                checks++;
                if ({s1_out, s2_out} !== 2'b10) begin
                    errors++;
                    $display("FAIL parity_bits got even=%b odd=%b exp even=1 odd=0", s1_out, s2_out);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_busy;
        logic [2:0] exp;
        int dones;
        dones = 0;
        @(negedge clk); s0_start = 1'b1; s0_data = 8'h3C;
        @(negedge clk); s0_start = 1'b0;
        for (int t = 0; t <= 130; t++) begin
            if (t < 100)       exp = {exp_bit(9'h03C, 8, 0, 0, t / 10), 2'b10};
            else if (t == 100) exp = 3'b101;
            else               exp = 3'b100;
            if (s0_done === 1'b1) dones++;
            checks++;
            if ({s0_out, s0_busy, s0_done} !== exp) begin
                errors++;
                $display("FAIL ignore_busy t=%0d got %b exp %b", t, {s0_out, s0_busy, s0_done}, exp);
            end
            if (t == 24) begin s0_start = 1'b1; s0_data = 8'hFF; end
            if (t == 25) begin s0_start = 1'b0; s0_data = 8'h12; end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_done_count got %0d exp 1", dones);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp;
        int first_done, second_done;
        first_done = -1; second_done = -1;
        @(negedge clk); s0_start = 1'b1; s0_data = 8'h55;
        @(negedge clk);
        for (int t = 0; t <= 202; t++) begin
            if (t < 100)                  exp = {exp_bit(9'h055, 8, 0, 0, t / 10), 2'b10};
            else if (t == 100)            exp = 3'b101;
            else if (t >= 101 && t < 201) exp = {exp_bit(9'h055, 8, 0, 0, (t - 101) / 10), 2'b10};
            else if (t == 201)            exp = 3'b101;
            else                          exp = 3'b100;
            if (s0_done === 1'b1) begin
                if (first_done < 0) first_done = t;
                else second_done = t;
            end
            checks++;
            if ({s0_out, s0_busy, s0_done} !== exp) begin
                errors++;
                $display("FAIL back_to_back t=%0d got %b exp %b", t, {s0_out, s0_busy, s0_done}, exp);
            end
            if (t == 201) s0_start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (second_done - first_done !== 101) begin
            errors++;
            $display("FAIL b2b_done_spacing got %0d exp 101", second_done - first_done);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [2:0] exp;
        @(negedge clk); s0_start = 1'b1; s0_data = 8'hA5;
        @(negedge clk); s0_start = 1'b0;
        for (int t = 0; t <= 42; t++) begin
            exp = {exp_bit(9'h0A5, 8, 0, 0, t / 10), 2'b10};
            checks++;
            if ({s0_out, s0_busy, s0_done} !== exp) begin
                errors++;
                $display("FAIL pre_reset t=%0d got %b exp %b", t, {s0_out, s0_busy, s0_done}, exp);
            end
            if (t < 42) @(negedge clk);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({s0_out, s0_busy, s0_done} !== 3'b100) begin
            errors++;
            $display("FAIL async_reset got %b exp 100", {s0_out, s0_busy, s0_done});
        end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            checks++;
            if ({s0_out, s0_busy, s0_done} !== 3'b100) begin
                errors++;
                $display("FAIL post_reset_idle t=%0d got %b exp 100", t, {s0_out, s0_busy, s0_done});
            end
        end
        @(negedge clk); s0_start = 1'b1; s0_data = 8'h81;
        @(negedge clk); s0_start = 1'b0;
        for (int t = 0; t <= 101; t++) begin
            if (t < 100)       exp = {exp_bit(9'h081, 8, 0, 0, t / 10), 2'b10};
            else if (t == 100) exp = 3'b101;
            else               exp = 3'b100;
            checks++;
            if ({s0_out, s0_busy, s0_done} !== exp) begin
                errors++;
                $display("FAIL frame_81 t=%0d got %b exp %b", t, {s0_out, s0_busy, s0_done}, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_rst    = 1'b0;
        s0_start = 1'b0; s1_start = 1'b0; s2_start = 1'b0;
        s0_data  = 8'h00; s1_data = 8'h00; s2_data = 8'h00;
        test_reset;
        test_frame_a5;
        test_parity;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid_frame;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
